// File: rtl/icache_direct.sv
// Direct-mapped, one-word-per-line instruction cache with zero-latency hits
// and a single outstanding word refill to the memory controller.
module icache_direct #(
    parameter int INDEX_W = 7,
    parameter int ADDR_W  = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_enable_in,
    input  logic [31:0] inst_addr_in,
    output logic        inst_enable_out,
    output logic [31:0] inst_value_out,
    output logic        mem_req_out,
    output logic [31:0] mem_addr_out,
    input  logic        mem_done_in,
    input  logic [31:0] mem_data_in
);

    localparam int LINES = 1 << INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic {IDLE, MISS} state_t;

    state_t             state;
    state_t             next_state;
    logic [LINES-1:0]   valid;
    logic [TAG_W-1:0]   tag_mem  [LINES];
    logic [31:0]        data_mem [LINES];

    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   req_tag;
    logic [INDEX_W-1:0] miss_idx;
    logic [TAG_W-1:0]   miss_tag;
    logic               hit;
    logic               start_miss;
    logic               refill_done;

    assign idx     = inst_addr_in[INDEX_W+1:2];
    assign req_tag = inst_addr_in[ADDR_W-1:INDEX_W+2];

    // The registered refill address doubles as the latched miss address.
    assign miss_idx = mem_addr_out[INDEX_W+1:2];
    assign miss_tag = mem_addr_out[ADDR_W-1:INDEX_W+2];

    assign hit             = rst && inst_enable_in && valid[idx] && (tag_mem[idx] == req_tag);
    assign inst_enable_out = hit;
    assign inst_value_out  = hit ? data_mem[idx] : 32'h0;

    always_comb begin
        next_state  = state;
        start_miss  = 1'b0;
        refill_done = 1'b0;
        case (state)
            IDLE: begin
                if (inst_enable_in && !hit) begin
                    next_state = MISS;
                    start_miss = 1'b1;
                end
            end
            MISS: begin
                if (mem_done_in) begin
                    next_state  = IDLE;
                    refill_done = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            mem_req_out  <= 1'b0;
            mem_addr_out <= 32'h0;
            valid        <= '0;
        end else begin
            state <= next_state;
            if (start_miss) begin
                mem_req_out  <= 1'b1;
                mem_addr_out <= inst_addr_in & ~32'h3;
            end else if (refill_done) begin
                mem_req_out <= 1'b0;
            end
            if (refill_done) begin
                valid[miss_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (refill_done) begin
            tag_mem[miss_idx]  <= miss_tag;
            data_mem[miss_idx] <= mem_data_in;
        end
    end

endmodule
